traffic_sink: RTL and testbench
===============================

// Module: traffic_sink
// PURPOSE
//  Receiving end of the local-port packet protocol: terminates packets that a router ejects to its tile.
//  Grants the i_rec_req/o_rec_ack handshake and checks HEAD/BODY/TAIL framing and destination address.
//  Measures end-to-end latency from the 16-bit stamp that the sender places in the TAIL flit.
//  One instance per tile, beside that tile's traffic generator. Statistics are read by the testbench.
// PARAMETERS
//  BODY_COUNT   2             body flits per packet, exact; 1..255
//  router_conf  ROUTER_CONFIG own xaddr/yaddr; HEAD destination is compared against these
//  TIMEOUT      64            max consecutive bubble cycles inside a packet; >=2
//  CHECK_ADDR   1             1 = enforce destination match, 0 = skip the address check
// PORTS
//  clk          in   1          clock
//  reset_n      in   1          asynchronous active-low reset
//  i_start      in   1          enable; when low, no new packet is granted
//  i_flit       in   FLIT_t     flit from the router; valid = flit[FLIT_SIZE-1]; type in head.flit_type
//  i_rec_req    in   1          upstream requests to deliver one packet
//  o_rec_ack    out  1          registered grant; held high for the whole packet
//  o_pkt_done   out  1          1-cycle pulse when a good TAIL is accepted
//  o_err        out  1          1-cycle pulse on a detected error
//  o_err_code   out  3          last error: 0 none, 1 addr, 2 type/order, 3 body count, 4 timeout
//  o_pkt_count  out  32         good packets; wraps
//  o_err_count  out  16         errors; saturates at 16'hFFFF
//  o_lat_last   out  16         latency of the last good packet
//  o_lat_min    out  16         minimum latency; reset value 16'hFFFF
//  o_lat_max    out  16         maximum latency
//  o_lat_sum    out  32         sum of latencies; saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  - Reset: every output 0, except o_lat_min = 16'hFFFF. FSM goes to IDLE. Timestamp ts (16 b) = 0.
//  - ts is a free-running counter that increments every cycle. All tiles leave reset together, so ts is globally aligned.
//  - FSM states: IDLE, WAIT_HEAD, BODY, WAIT_TAIL, FLUSH. All outputs are registered.
//  - IDLE: o_rec_ack=0. If i_start && i_rec_req, next state is WAIT_HEAD with o_rec_ack=1 in the next cycle.
//  - Flits are sampled only while o_rec_ack=1. A cycle with valid=0 is a bubble.
//  - Bubble counter: cleared by any valid flit, incremented on each bubble.
//  - Bubble counter reaching TIMEOUT in WAIT_HEAD, BODY or WAIT_TAIL: error 4, then IDLE.
//  - WAIT_HEAD: the first valid flit must be HEAD, otherwise error 2.
//  - HEAD check: with CHECK_ADDR=1, xaddr/yaddr must equal router_conf, otherwise error 1.
//  - A good HEAD moves to BODY and clears the body counter (8 b).
//  - BODY: each BODY flit increments the counter. The counter reaching BODY_COUNT moves to WAIT_TAIL.
//  - BODY: a TAIL before the count is reached gives error 3. HEAD or NONE_FLIT gives error 2.
//  - WAIT_TAIL: the next valid flit must be TAIL. A BODY flit gives error 3; any other type gives error 2.
//  - TAIL accept, latency: lat = ts - tail[15:0], modulo 2^16, unsigned.
//  - TAIL accept, statistics: update o_lat_last, o_lat_min and o_lat_max. Add lat to o_lat_sum. Increment o_pkt_count.
//  - TAIL accept, outputs: pulse o_pkt_done. Next state IDLE, so o_rec_ack falls in the next cycle.
//  - Error (codes 1-3): pulse o_err, latch o_err_code, increment o_err_count, go to FLUSH.
//  - FLUSH: o_rec_ack stays high and flits are discarded. Leave to IDLE on any valid TAIL or on TIMEOUT bubbles.
//  - A TIMEOUT during FLUSH sets no new error.
//  - Statistics are never updated for an errored packet.
//  - After any packet there is at least one IDLE cycle. An i_rec_req arriving with the TAIL is granted 2 cycles later.
//  - i_start falling mid-packet does not abort; the current packet completes or flushes.
//  - Asynchronous reset mid-packet: immediate return to the reset values; statistics are lost.
//  - o_pkt_done and o_err are never high in the same cycle.
// TESTING
//  - Good packet: req@t0 -> ack=1@t1; HEAD(own), 2xBODY, TAIL stamp=ts-5, back-to-back -> pkt_done, lat_last=5, pkt_count=1, ack=0 next cycle.
//  - Bubbles: 3 bubbles between BODY flits, TIMEOUT=64 -> accepted; 64 bubbles -> err_code=4, err_count=1, IDLE.
//  - Bad addr: HEAD x=1,y=0 at tile (3,3) -> err_code=1; FLUSH until TAIL; pkt_count unchanged; next good packet accepted.
//  - Order: BODY first -> code 2; TAIL after 1 BODY -> code 3; 3 BODY -> code 3.
//  - Stats: latencies 7, 3, 12 -> min=3, max=12, sum=22. Stamp wrap (ts=2, stamp=16'hFFFE) -> lat=4.
//  - Reset: assert reset_n=0 in BODY -> ack=0, counters=0, lat_min=16'hFFFF. CHECK_ADDR=0: foreign HEAD accepted.

Source files
------------

// File: rtl/traffic_sink.sv
// traffic_sink: terminates ejected packets, checks HEAD/BODY/TAIL framing and destination,
// and accumulates end-to-end latency statistics from the TAIL timestamp.
package traffic_pkg;
  localparam int FLIT_SIZE = 35;
  typedef enum logic [1:0] {NONE_FLIT, HEAD_FLIT, BODY_FLIT, TAIL_FLIT} flit_type_t;
  typedef logic [FLIT_SIZE-1:0] FLIT_t;
  typedef struct packed {
    logic       valid;
    flit_type_t flit_type;
    logic [3:0] xaddr;
    logic [3:0] yaddr;
    logic [23:0] rsvd;
  } head_t;
  typedef struct packed {
    logic [3:0] xaddr;
    logic [3:0] yaddr;
  } ROUTER_CONFIG;
endpackage

module traffic_sink
  import traffic_pkg::*;
#(
  parameter int           BODY_COUNT  = 2,
  parameter ROUTER_CONFIG router_conf = '{xaddr: 4'd0, yaddr: 4'd0},
  parameter int           TIMEOUT     = 64,
  parameter bit           CHECK_ADDR  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_start,
  input  FLIT_t       i_flit,
  input  logic        i_rec_req,
  output logic        o_rec_ack,
  output logic        o_pkt_done,
  output logic        o_err,
  output logic [2:0]  o_err_code,
  output logic [31:0] o_pkt_count,
  output logic [15:0] o_err_count,
  output logic [15:0] o_lat_last,
  output logic [15:0] o_lat_min,
  output logic [15:0] o_lat_max,
  output logic [31:0] o_lat_sum
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WAIT_HEAD, BODY, WAIT_TAIL, FLUSH} state_t;

  state_t        state_q, nxt;
  logic          ack_q, done_q, err_q;
  logic [2:0]    err_code_q, code;
  logic [31:0]   pkt_count_q, lat_sum_q;
  logic [15:0]   err_count_q, lat_last_q, lat_min_q, lat_max_q, ts_q, lat;
  logic [7:0]    cnt_q;
  logic [TW-1:0] bub_q, bub_nx;
  logic [32:0]   sum_nx;
  logic          valid, addr_ok, tmo, acc, unused_bits;
  flit_type_t    ftype;
  head_t         hd;

  assign hd          = head_t'(i_flit);
  assign valid       = hd.valid;
  assign ftype       = hd.flit_type;
  assign addr_ok     = !CHECK_ADDR || (hd.xaddr == router_conf.xaddr && hd.yaddr == router_conf.yaddr);
  assign bub_nx      = bub_q + TW'(1);
  assign tmo         = (state_q != IDLE) && !valid && (bub_nx == TW'(TIMEOUT));
  assign lat         = ts_q - i_flit[15:0];
  assign sum_nx      = {1'b0, lat_sum_q} + {17'd0, lat};
  assign unused_bits = ^hd.rsvd[23:16];

  // Error codes override the framing-driven next state; a timeout is only possible on a bubble.
  always_comb begin
    nxt  = state_q;
    code = 3'd0;
    acc  = 1'b0;
    case (state_q)
      IDLE: nxt = (i_start && i_rec_req) ? WAIT_HEAD : IDLE;
      WAIT_HEAD: if (valid) begin
        code = (ftype != HEAD_FLIT) ? 3'd2 : (!addr_ok ? 3'd1 : 3'd0);
        nxt  = BODY;
      end
      BODY: if (valid) begin
        code = (ftype == TAIL_FLIT) ? 3'd3 : (ftype != BODY_FLIT) ? 3'd2 : 3'd0;
        nxt  = (cnt_q + 8'd1 == 8'(BODY_COUNT)) ? WAIT_TAIL : BODY;
      end
      WAIT_TAIL: if (valid) begin
        code = (ftype == BODY_FLIT) ? 3'd3 : (ftype != TAIL_FLIT) ? 3'd2 : 3'd0;
        acc  = (ftype == TAIL_FLIT);
        nxt  = IDLE;
      end
      FLUSH: nxt = ((valid && ftype == TAIL_FLIT) || tmo) ? IDLE : FLUSH;
      default: nxt = IDLE;
    endcase
    if (tmo && state_q != FLUSH) code = 3'd4;
    if (code != 3'd0) nxt = (code == 3'd4) ? IDLE : FLUSH;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ts_q        <= '0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      bub_q       <= '0;
      cnt_q       <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
      lat_last_q  <= '0;
      lat_min_q   <= 16'hFFFF;
      lat_max_q   <= '0;
      lat_sum_q   <= '0;
    end else begin
      ts_q    <= ts_q + 16'd1;
      state_q <= nxt;
      ack_q   <= (nxt != IDLE);
      bub_q   <= (state_q == IDLE || valid) ? '0 : bub_nx;
      cnt_q   <= (state_q == WAIT_HEAD) ? 8'd0 :
                 (state_q == BODY && valid && ftype == BODY_FLIT) ? cnt_q + 8'd1 : cnt_q;
      done_q  <= acc;
      err_q   <= (code != 3'd0);
      if (code != 3'd0) begin
        err_code_q  <= code;
        err_count_q <= (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
      end
      if (acc) begin
        lat_last_q  <= lat;
        lat_min_q   <= (lat < lat_min_q) ? lat : lat_min_q;
        lat_max_q   <= (lat > lat_max_q) ? lat : lat_max_q;
        lat_sum_q   <= sum_nx[32] ? 32'hFFFF_FFFF : sum_nx[31:0];
        pkt_count_q <= pkt_count_q + 32'd1;
      end
    end
  end

  assign o_rec_ack   = ack_q;
  assign o_pkt_done  = done_q;
  assign o_err       = err_q;
  assign o_err_code  = err_code_q;
  assign o_pkt_count = pkt_count_q;
  assign o_err_count = err_count_q;
  assign o_lat_last  = lat_last_q;
  assign o_lat_min   = lat_min_q;
  assign o_lat_max   = lat_max_q;
  assign o_lat_sum   = lat_sum_q;
endmodule

// File: tb/tb_traffic_sink.sv
// tb_traffic_sink: directed scoreboard bench for traffic_sink at tile (3,3), plus a CHECK_ADDR=0 twin.
module tb_traffic_sink;
  import traffic_pkg::*;

  logic clk = 1'b0, reset_n = 1'b0, i_start = 1'b0, i_rec_req = 1'b0;
  FLIT_t i_flit = '0;
  logic o_rec_ack, o_pkt_done, o_err, d2_rec_ack, d2_pkt_done, d2_err;
  logic [2:0] o_err_code, d2_err_code;
  logic [31:0] o_pkt_count, o_lat_sum, d2_pkt_count, d2_lat_sum;
  logic [15:0] o_err_count, o_lat_last, o_lat_min, o_lat_max;
  logic [15:0] d2_err_count, d2_lat_last, d2_lat_min, d2_lat_max;
  logic [15:0] tb_ts, w;
  int tests = 0, fails = 0;

  typedef struct {bit is_err; logic [2:0] code; logic [15:0] lat;} ev_t;
  ev_t sbq[$];

  traffic_sink #(.BODY_COUNT(2), .router_conf(ROUTER_CONFIG'(8'h33)), .TIMEOUT(64), .CHECK_ADDR(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_flit(i_flit), .i_rec_req(i_rec_req),
    .o_rec_ack(o_rec_ack), .o_pkt_done(o_pkt_done), .o_err(o_err), .o_err_code(o_err_code),
    .o_pkt_count(o_pkt_count), .o_err_count(o_err_count), .o_lat_last(o_lat_last),
    .o_lat_min(o_lat_min), .o_lat_max(o_lat_max), .o_lat_sum(o_lat_sum));

  traffic_sink #(.BODY_COUNT(2), .router_conf(ROUTER_CONFIG'(8'h33)), .TIMEOUT(64), .CHECK_ADDR(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_flit(i_flit), .i_rec_req(i_rec_req),
    .o_rec_ack(d2_rec_ack), .o_pkt_done(d2_pkt_done), .o_err(d2_err), .o_err_code(d2_err_code),
    .o_pkt_count(d2_pkt_count), .o_err_count(d2_err_count), .o_lat_last(d2_lat_last),
    .o_lat_min(d2_lat_min), .o_lat_max(d2_lat_max), .o_lat_sum(d2_lat_sum));

  always #5 clk = ~clk;

  // Reference timestamp: the value the sink's counter holds when the next flit is sampled.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) tb_ts <= '0;
    else tb_ts <= tb_ts + 16'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic FLIT_t mk(input flit_type_t t, input logic [31:0] d);
    return {1'b1, t, d};
  endfunction
  function automatic FLIT_t head(input logic [3:0] x, input logic [3:0] y);
    return mk(HEAD_FLIT, {x, y, 24'h0});
  endfunction
  function automatic FLIT_t tail(input logic [15:0] s);
    return mk(TAIL_FLIT, {16'h0, s});
  endfunction

  task automatic exp_done(input logic [15:0] lat);
    sbq.push_back('{is_err: 1'b0, code: 3'd0, lat: lat});
  endtask
  task automatic exp_err(input logic [2:0] c);
    sbq.push_back('{is_err: 1'b1, code: c, lat: 16'd0});
  endtask

  task automatic drive(input FLIT_t f);
    ev_t e;
    i_flit = f;
    @(posedge clk);
    #1;
    i_flit = '0;
    chk("excl", {31'd0, o_pkt_done & o_err}, 32'd0);
    if (o_pkt_done || o_err) begin
      if (sbq.size() == 0) chk("sb_unexpected", {30'd0, o_err, o_pkt_done}, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("ev_kind", {31'd0, o_err}, {31'd0, e.is_err});
        if (e.is_err) chk("err_code", {29'd0, o_err_code}, {29'd0, e.code});
        else chk("lat_last", {16'd0, o_lat_last}, {16'd0, e.lat});
      end
    end
  endtask

  task automatic grant();
    i_rec_req = 1'b1;
    @(posedge clk);
    #1;
    i_rec_req = 1'b0;
    chk("grant", {31'd0, o_rec_ack}, 32'd1);
  endtask

  task automatic good_pkt(input logic [15:0] lat, input int nbub);
    grant();
    drive(head(4'd3, 4'd3));
    drive(mk(BODY_FLIT, 32'hB0D1_0001));
    for (int i = 0; i < nbub; i++) drive('0);
    drive(mk(BODY_FLIT, 32'hB0D1_0002));
    exp_done(lat);
    drive(tail(tb_ts - lat));
    chk("sb_empty", sbq.size(), 32'd0);
    chk("ack_fall", {31'd0, o_rec_ack}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    i_flit = '0;
    i_rec_req = 1'b0;
    #1;
    chk("rst_ack", {31'd0, o_rec_ack}, 32'd0);
    chk("rst_done", {31'd0, o_pkt_done}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_code", {29'd0, o_err_code}, 32'd0);
    chk("rst_pkts", o_pkt_count, 32'd0);
    chk("rst_errs", {16'd0, o_err_count}, 32'd0);
    chk("rst_last", {16'd0, o_lat_last}, 32'd0);
    chk("rst_min", {16'd0, o_lat_min}, 32'h0000_FFFF);
    chk("rst_max", {16'd0, o_lat_max}, 32'd0);
    chk("rst_sum", o_lat_sum, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    apply_reset();
    i_start = 1'b1;

    good_pkt(16'd5, 0);
    chk("pkt_count_1", o_pkt_count, 32'd1);

    good_pkt(16'd1, 3);
    chk("pkt_count_bub", o_pkt_count, 32'd2);

    grant();
    drive(head(4'd3, 4'd3));
    for (int i = 0; i < 63; i++) drive('0);
    exp_err(3'd4);
    drive('0);
    chk("tmo_errs", {16'd0, o_err_count}, 32'd1);
    chk("tmo_ack", {31'd0, o_rec_ack}, 32'd0);
    chk("tmo_sb", sbq.size(), 32'd0);

    grant();
    exp_err(3'd1);
    drive(head(4'd1, 4'd0));
    drive(mk(BODY_FLIT, 32'h1));
    drive(mk(BODY_FLIT, 32'h2));
    chk("flush_ack", {31'd0, o_rec_ack}, 32'd1);
    drive(tail(16'h0));
    chk("addr_ack", {31'd0, o_rec_ack}, 32'd0);
    chk("addr_pkts", o_pkt_count, 32'd2);
    chk("addr_last", {16'd0, o_lat_last}, 32'd1);
    good_pkt(16'd2, 0);
    chk("addr_next", o_pkt_count, 32'd3);

    grant();
    exp_err(3'd2);
    drive(mk(BODY_FLIT, 32'h0));
    drive(tail(16'h0));
    grant();
    drive(head(4'd3, 4'd3));
    drive(mk(BODY_FLIT, 32'h0));
    exp_err(3'd3);
    drive(tail(16'h0));
    drive(tail(16'h0));
    grant();
    drive(head(4'd3, 4'd3));
    drive(mk(BODY_FLIT, 32'h0));
    drive(mk(BODY_FLIT, 32'h0));
    exp_err(3'd3);
    drive(mk(BODY_FLIT, 32'h0));
    drive(tail(16'h0));
    chk("order_errs", {16'd0, o_err_count}, 32'd5);
    chk("order_pkts", o_pkt_count, 32'd3);
    chk("order_sb", sbq.size(), 32'd0);

    i_start = 1'b0;
    i_rec_req = 1'b1;
    @(posedge clk);
    #1;
    chk("nostart_ack", {31'd0, o_rec_ack}, 32'd0);
    i_rec_req = 1'b0;
    i_start = 1'b1;

    grant();
    drive(head(4'd3, 4'd3));
    drive(mk(BODY_FLIT, 32'h0));
    apply_reset();

    grant();
    drive(head(4'd3, 4'd3));
    drive(mk(BODY_FLIT, 32'h0));
    drive(mk(BODY_FLIT, 32'h0));
    w = tb_ts - 16'hFFFE;
    exp_done(w);
    drive(tail(16'hFFFE));
    chk("wrap_last", {16'd0, o_lat_last}, {16'd0, w});

    apply_reset();
    good_pkt(16'd7, 0);
    good_pkt(16'd3, 1);
    good_pkt(16'd12, 0);
    chk("stat_min", {16'd0, o_lat_min}, 32'd3);
    chk("stat_max", {16'd0, o_lat_max}, 32'd12);
    chk("stat_sum", o_lat_sum, 32'd22);
    chk("stat_pkts", o_pkt_count, 32'd3);

    apply_reset();
    grant();
    exp_err(3'd1);
    drive(head(4'd1, 4'd0));
    drive(mk(BODY_FLIT, 32'h0));
    drive(mk(BODY_FLIT, 32'h0));
    drive(tail(tb_ts - 16'd9));
    chk("noaddr_pkts", d2_pkt_count, 32'd1);
    chk("noaddr_last", {16'd0, d2_lat_last}, 32'd9);
    chk("noaddr_errs", {16'd0, d2_err_count}, 32'd0);
    chk("addr_chk_pkts", o_pkt_count, 32'd0);
    chk("final_sb", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
